lock_controller: RTL and testbench

LOCK_CONTROLLER -- requirements
Module: lock_controller

---
 rtl/lock_pkg.sv | 16 +
 rtl/lock_timer.sv | 29 ++
 rtl/lock_controller.sv | 112 +++++++++++
 tb/tb_lock_controller.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared encodings and widths for the combination lock controller.
package lock_pkg;

    localparam int CODE_W  = 4;
    localparam int TRIES_W = 3;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_SET     = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that holds at zero; shared by the OPEN and LOCKOUT dwell periods.
module lock_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments only, and clr is
    // sampled inside the clocked block so the reset is synchronous.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/lock_controller.sv
// Combination lock FSM: password entry, guess checking, timed open and lockout.
module lock_controller
    import lock_pkg::*;
#(
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int OPEN_CYCLES    = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [CODE_W-1:0]  code,
    input  logic               commit,
    input  logic               reprog,
    output logic               sel,
    output logic               unlocked,
    output logic               alarm,
    output logic               fail,
    output logic [TRIES_W-1:0] tries_left,
    output logic [STATE_W-1:0] state
);

    localparam int TMR_MAX = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TRIES_W-1:0] TRIES_INIT = TRIES_W'(MAX_TRIES);

    state_t             cur_st, nxt_st;
    logic [CODE_W-1:0]  pw, guess;
    logic               match, last_try;
    logic               tmr_load, tmr_en, tmr_zero;
    logic [TMR_W-1:0]   tmr_val;

    assign match    = (guess == pw);
    assign last_try = (tries_left <= TRIES_W'(1));

    // Timer runs N-1 down to 0 and the state exits on the edge after zero,
    // so OPEN and LOCKOUT each last exactly their parameter in cycles.
    assign tmr_load = (cur_st == ST_CHECK);
    assign tmr_val  = match ? TMR_W'(OPEN_CYCLES - 1) : TMR_W'(LOCKOUT_CYCLES - 1);
    assign tmr_en   = (cur_st == ST_OPEN) || (cur_st == ST_LOCKOUT);

    lock_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .clr      (clr),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (clr) cur_st <= ST_SET;
        else     cur_st <= nxt_st;
    end

    // NOTE: nxt_st gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            ST_SET:     if (commit) nxt_st = ST_ARMED;
            ST_ARMED:   if (commit) nxt_st = ST_CHECK;
            ST_CHECK: begin
                if (match)         nxt_st = ST_OPEN;
                else if (last_try) nxt_st = ST_LOCKOUT;
                else               nxt_st = ST_ARMED;
            end
            ST_OPEN: begin
                if (reprog)        nxt_st = ST_SET;
                else if (tmr_zero) nxt_st = ST_ARMED;
            end
            ST_LOCKOUT: if (tmr_zero) nxt_st = ST_ARMED;
            default:    nxt_st = ST_SET;
        endcase
    end

    always_comb begin
        sel      = (cur_st != ST_SET);
        unlocked = (cur_st == ST_OPEN);
        alarm    = (cur_st == ST_LOCKOUT);
        state    = cur_st;
    end

    // Password, guess, retry budget and the registered fail pulse.
    always_ff @(posedge clk) begin
        if (clr) begin
            pw         <= '0;
            guess      <= '0;
            tries_left <= TRIES_INIT;
            fail       <= 1'b0;
        end else begin
            fail <= 1'b0;
            case (cur_st)
                ST_SET: if (commit) begin
                    pw         <= code;
                    tries_left <= TRIES_INIT;
                end
                ST_ARMED: if (commit) guess <= code;
                ST_CHECK: begin
                    if (match) begin
                        tries_left <= TRIES_INIT;
                    end else begin
                        fail       <= 1'b1;
                        tries_left <= (tries_left != '0) ? tries_left - TRIES_W'(1) : '0;
                    end
                end
                ST_LOCKOUT: if (tmr_zero) tries_left <= TRIES_INIT;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lock_controller.sv
// Directed self-checking bench for lock_controller with default parameters.
module tb_lock_controller;
    import lock_pkg::*;

    logic               clk = 1'b0;
    logic               clr = 1'b0;
    logic [CODE_W-1:0]  code = '0;
    logic               commit = 1'b0;
    logic               reprog = 1'b0;
    logic               sel, unlocked, alarm, fail;
    logic [TRIES_W-1:0] tries_left;
    logic [STATE_W-1:0] state;

    int checks = 0;
    int errors = 0;

    lock_controller #(.MAX_TRIES(3), .LOCKOUT_CYCLES(16), .OPEN_CYCLES(8)) dut (
        .clk        (clk),
        .clr        (clr),
        .code       (code),
        .commit     (commit),
        .reprog     (reprog),
        .sel        (sel),
        .unlocked   (unlocked),
        .alarm      (alarm),
        .fail       (fail),
        .tries_left (tries_left),
        .state      (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic pulse_commit(input logic [CODE_W-1:0] c);
        code   = c;
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic test_reset();
        do_clr();
        checks++; if (state !== ST_SET) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, ST_SET); end
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL reset_sel: got %b expected 0", sel); end
        checks++; if (unlocked !== 1'b0 || alarm !== 1'b0 || fail !== 1'b0) begin errors++; $display("FAIL reset_flags: got unlocked=%b alarm=%b fail=%b expected 000", unlocked, alarm, fail); end
        checks++; if (tries_left !== 3'd3) begin errors++; $display("FAIL reset_tries: got %0d expected 3", tries_left); end
    endtask

    task automatic test_set_unlock();
        int n;
        pulse_commit(4'hA);
        checks++; if (state !== ST_ARMED || sel !== 1'b1) begin errors++; $display("FAIL set_armed: got state=%0d sel=%b expected state=%0d sel=1", state, sel, ST_ARMED); end
        pulse_commit(4'hA);
        checks++; if (state !== ST_CHECK || unlocked !== 1'b0) begin errors++; $display("FAIL check_state: got state=%0d unlocked=%b expected state=%0d unlocked=0", state, unlocked, ST_CHECK); end
        tick();
        checks++; if (unlocked !== 1'b1 || tries_left !== 3'd3 || fail !== 1'b0) begin errors++; $display("FAIL unlock: got unlocked=%b tries=%0d fail=%b expected 1,3,0", unlocked, tries_left, fail); end
        n = 0;
        while (state == ST_OPEN && n < 40) begin n++; tick(); end
        checks++; if (n != 8) begin errors++; $display("FAIL open_len: got %0d cycles expected 8", n); end
        checks++; if (state !== ST_ARMED || unlocked !== 1'b0) begin errors++; $display("FAIL open_exit: got state=%0d unlocked=%b expected state=%0d unlocked=0", state, unlocked, ST_ARMED); end
    endtask

    task automatic test_lockout();
        int n;
        do_clr();
        pulse_commit(4'h5);
        for (int i = 0; i < 3; i++) begin
            pulse_commit(4'h3);
            tick();
            checks++; if (fail !== 1'b1 || tries_left !== 3'(2 - i)) begin errors++; $display("FAIL wrong_guess_%0d: got fail=%b tries=%0d expected fail=1 tries=%0d", i, fail, tries_left, 2 - i); end
            checks++; if (state !== ((i == 2) ? ST_LOCKOUT : ST_ARMED)) begin errors++; $display("FAIL wrong_state_%0d: got %0d", i, state); end
        end
        checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL alarm_on: got %b expected 1", alarm); end
        n = 0;
        while (alarm == 1'b1 && n < 64) begin
            n++;
            if (n == 3) begin code = 4'h5; commit = 1'b1; end
            if (n == 6) reprog = 1'b1;
            tick();
            commit = 1'b0;
            reprog = 1'b0;
            if (n == 3 || n == 6) begin
                checks++; if (alarm !== 1'b1 || unlocked !== 1'b0) begin errors++; $display("FAIL lockout_immune_%0d: got alarm=%b unlocked=%b expected 1,0", n, alarm, unlocked); end
            end
        end
        checks++; if (n != 16) begin errors++; $display("FAIL lockout_len: got %0d cycles expected 16", n); end
        checks++; if (state !== ST_ARMED || tries_left !== 3'd3) begin errors++; $display("FAIL lockout_exit: got state=%0d tries=%0d expected state=%0d tries=3", state, tries_left, ST_ARMED); end
        pulse_commit(4'h5);
        tick();
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL post_lockout_unlock: got %b expected 1", unlocked); end
    endtask

    task automatic test_reprogram();
        code = 4'h7; reprog = 1'b1; commit = 1'b1;
        tick();
        reprog = 1'b0; commit = 1'b0;
        checks++; if (state !== ST_SET || sel !== 1'b0) begin errors++; $display("FAIL reprog_set: got state=%0d sel=%b expected state=%0d sel=0", state, sel, ST_SET); end
        pulse_commit(4'hC);
        reprog = 1'b1;
        tick();
        reprog = 1'b0;
        checks++; if (state !== ST_ARMED) begin errors++; $display("FAIL reprog_armed_ignored: got %0d expected %0d", state, ST_ARMED); end
        pulse_commit(4'h5);
        tick();
        checks++; if (fail !== 1'b1 || unlocked !== 1'b0) begin errors++; $display("FAIL old_pw_rejected: got fail=%b unlocked=%b expected 1,0", fail, unlocked); end
        pulse_commit(4'h7);
        tick();
        checks++; if (fail !== 1'b1 || tries_left !== 3'd1) begin errors++; $display("FAIL dropped_commit_pw: got fail=%b tries=%0d expected 1,1", fail, tries_left); end
        pulse_commit(4'hC);
        tick();
        checks++; if (unlocked !== 1'b1 || tries_left !== 3'd3) begin errors++; $display("FAIL new_pw_unlock: got unlocked=%b tries=%0d expected 1,3", unlocked, tries_left); end
    endtask

    task automatic test_reset_mid();
        do_clr();
        checks++; if (state !== ST_SET || unlocked !== 1'b0 || sel !== 1'b0 || tries_left !== 3'd3 || fail !== 1'b0 || alarm !== 1'b0) begin errors++; $display("FAIL clr_open: got state=%0d unlocked=%b sel=%b tries=%0d", state, unlocked, sel, tries_left); end
        pulse_commit(4'h9);
        for (int i = 0; i < 3; i++) begin
            pulse_commit(4'hC);
            tick();
            if (i == 0) begin
                checks++; if (fail !== 1'b1 || unlocked !== 1'b0) begin errors++; $display("FAIL clr_old_pw: got fail=%b unlocked=%b expected 1,0", fail, unlocked); end
            end
        end
        checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL lockout_before_clr: got alarm=%b expected 1", alarm); end
        tick(); tick(); tick();
        do_clr();
        checks++; if (state !== ST_SET || alarm !== 1'b0 || sel !== 1'b0 || tries_left !== 3'd3 || fail !== 1'b0) begin errors++; $display("FAIL clr_lockout: got state=%0d alarm=%b sel=%b tries=%0d", state, alarm, sel, tries_left); end
        pulse_commit(4'h2);
        pulse_commit(4'h9);
        tick();
        checks++; if (fail !== 1'b1 || unlocked !== 1'b0) begin errors++; $display("FAIL clr_old_pw2: got fail=%b unlocked=%b expected 1,0", fail, unlocked); end
    endtask

    task automatic test_edge_codes();
        do_clr();
        pulse_commit(4'h0);
        pulse_commit(4'hF);
        code = 4'h0; commit = 1'b1;
        tick();
        commit = 1'b0;
        checks++; if (fail !== 1'b1 || state !== ST_ARMED || tries_left !== 3'd2) begin errors++; $display("FAIL f_vs_0: got fail=%b state=%0d tries=%0d expected 1,%0d,2", fail, state, tries_left, ST_ARMED); end
        tick();
        checks++; if (state !== ST_ARMED || fail !== 1'b0) begin errors++; $display("FAIL check_commit_dropped: got state=%0d fail=%b expected %0d,0", state, fail, ST_ARMED); end
        pulse_commit(4'h0);
        tick();
        checks++; if (unlocked !== 1'b1 || tries_left !== 3'd3) begin errors++; $display("FAIL zero_pw_unlock: got unlocked=%b tries=%0d expected 1,3", unlocked, tries_left); end
        reprog = 1'b1;
        tick();
        reprog = 1'b0;
        pulse_commit(4'hF);
        pulse_commit(4'h0);
        tick();
        checks++; if (fail !== 1'b1 || unlocked !== 1'b0) begin errors++; $display("FAIL 0_vs_f: got fail=%b unlocked=%b expected 1,0", fail, unlocked); end
        pulse_commit(4'hF);
        tick();
        checks++; if (unlocked !== 1'b1 || fail !== 1'b0) begin errors++; $display("FAIL f_pw_unlock: got unlocked=%b fail=%b expected 1,0", unlocked, fail); end
    endtask

    initial begin
        test_reset();
        test_set_unlock();
        test_lockout();
        test_reprogram();
        test_reset_mid();
        test_edge_codes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
